fifo_param_sync: RTL

//  Parametrised synchronous FIFO; next generation of the single-config FIFO under test.

---
 rtl/fifo_param_sync_if.sv | 40 ++++
 rtl/fifo_param_sync.sv | 114 +++++++++++
 2 files changed

// File: rtl/fifo_param_sync_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_param_sync_if
// Brief    : Handshake/status bundle between a FIFO and its producer/consumer.
// Revision : 1.0
// ============================================================================
interface fifo_param_sync_if #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
);
    localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);

    logic                  flush;
    logic [FIFO_WIDTH-1:0] data_in;
    logic                  wr_en;
    logic                  rd_en;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  rd_valid;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  empty;
    logic                  almostfull;
    logic                  almostempty;
    logic [c_cnt_w-1:0]    count;

    modport master (
        output flush, data_in, wr_en, rd_en,
        input  data_out, rd_valid, wr_ack, overflow, underflow,
               full, empty, almostfull, almostempty, count
    );

    modport slave (
        input  flush, data_in, wr_en, rd_en,
        output data_out, rd_valid, wr_ack, overflow, underflow,
               full, empty, almostfull, almostempty, count
    );
endinterface
`default_nettype wire

// File: rtl/fifo_param_sync.sv
`default_nettype none
// ============================================================================
// Module   : fifo_param_sync
// Brief    : Parametrised single-clock FIFO, any depth, optional FWFT read.
// Revision : 1.0
// ============================================================================
module fifo_param_sync #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_THRESH  = 7,
    parameter int AE_THRESH  = 1,
    parameter int FWFT       = 0
) (
    input  wire logic          clk,
    input  wire logic          rst,
    fifo_param_sync_if.slave   bus
);
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);

    logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_cnt_w-1:0]    r_count;
    logic                  r_wr_ack;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_clear;
    logic w_full;
    logic w_empty;
    logic w_rd_accept;
    logic w_wr_accept;

    function automatic logic [c_ptr_w-1:0] f_next_ptr(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(FIFO_DEPTH - 1)) ? '0 : p + c_ptr_w'(1);
    endfunction

    assign w_clear     = rst | bus.flush;
    assign w_full      = (r_count == c_cnt_w'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_rd_accept = bus.rd_en & ~w_empty;
    // A full FIFO still takes a write when the same cycle frees a slot.
    assign w_wr_accept = bus.wr_en & (~w_full | w_rd_accept);

    always_ff @(posedge clk) begin
        if (!w_clear && w_wr_accept) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_wr_ack    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ack    <= w_wr_accept;
            r_overflow  <= bus.wr_en & ~w_wr_accept;
            r_underflow <= bus.rd_en & w_empty;
            if (w_wr_accept) begin
                r_wr_ptr <= f_next_ptr(r_wr_ptr);
            end
            if (w_rd_accept) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
            end
            case ({w_wr_accept, w_rd_accept})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [FIFO_WIDTH-1:0] r_data_out;
            logic                  r_rd_valid;

            // Rejected reads leave the last word on data_out.
            always_ff @(posedge clk) begin
                if (w_clear) begin
                    r_data_out <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_accept;
                    if (w_rd_accept) begin
                        r_data_out <= r_mem[r_rd_ptr];
                    end
                end
            end

            assign bus.data_out = r_data_out;
            assign bus.rd_valid = r_rd_valid;
        end else begin : g_fwft_read
            assign bus.data_out = w_empty ? '0 : r_mem[r_rd_ptr];
            assign bus.rd_valid = ~w_empty;
        end
    endgenerate

    assign bus.wr_ack      = r_wr_ack;
    assign bus.overflow    = r_overflow;
    assign bus.underflow   = r_underflow;
    assign bus.full        = w_full;
    assign bus.empty       = w_empty;
    assign bus.almostfull  = (r_count == c_cnt_w'(AF_THRESH));
    assign bus.almostempty = (r_count == c_cnt_w'(AE_THRESH));
    assign bus.count       = r_count;

endmodule
`default_nettype wire
